// File: rtl/brick_color_table.sv
// Colour table fed by the random colour generator's colour/counter stream.
// Captures one entry per counter change during LOAD and serves indexed reads in every state.
module brick_color_table #(
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  EMPTY_COLOR    = 8'hFF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load_start,
  input  logic [7:0] gen_color,
  input  logic [7:0] gen_counter,
  input  logic       rd_req,
  input  logic [7:0] rd_index,
  output logic [7:0] rd_color,
  output logic       rd_valid,
  output logic       loading,
  output logic       ready,
  output logic       load_error,
  output logic [8:0] filled_count
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          last_counter_q, last_counter_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                load_error_q, load_error_d;
  logic [8:0]          filled_q, filled_d;
  logic [255:0]        valid_q;
  logic [7:0]          table_q [256];
  logic [7:0]          rd_color_q;
  logic                rd_valid_q;
  logic                wr_en;

  // load_start takes priority over a coinciding counter change.
  assign wr_en = (state_q == S_LOAD) && !load_start && (gen_counter != last_counter_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    last_counter_d = last_counter_q;
    idle_cnt_d     = idle_cnt_q;
    load_error_d   = load_error_q;
    filled_d       = filled_q;
    if (load_start) begin
      state_d        = S_LOAD;
      last_counter_d = gen_counter;
      idle_cnt_d     = '0;
      load_error_d   = 1'b0;
      filled_d       = '0;
    end else if (state_q == S_LOAD) begin
      if (wr_en) begin
        last_counter_d = gen_counter;
        idle_cnt_d     = '0;
        if (!valid_q[gen_counter] && filled_q != 9'd256) filled_d = filled_q + 9'd1;
        if (gen_counter == 8'hFF) state_d = S_READY;
      end else if (idle_cnt_q == IDLE_MAX) begin
        state_d      = S_IDLE;
        load_error_d = 1'b1;
        idle_cnt_d   = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_IDLE;
      last_counter_q <= '0;
      idle_cnt_q     <= '0;
      load_error_q   <= 1'b0;
      filled_q       <= '0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      last_counter_q <= last_counter_d;
      idle_cnt_q     <= idle_cnt_d;
      load_error_q   <= load_error_d;
      filled_q       <= filled_d;
      if (load_start)  valid_q <= '0;
      else if (wr_en)  valid_q[gen_counter] <= 1'b1;
    end
  end

  // NOTE: the colour array has no reset; the valid bits alone decide whether an entry is visible.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[gen_counter] <= gen_color;
  end

  // Reading the pre-edge array gives read-before-write on a same-index collision.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_color_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_color_q <= valid_q[rd_index] ? table_q[rd_index] : EMPTY_COLOR;
    end
  end

  assign rd_color     = rd_color_q;
  assign rd_valid     = rd_valid_q;
  assign loading      = (state_q == S_LOAD);
  assign ready        = (state_q == S_READY);
  assign load_error   = load_error_q;
  assign filled_count = filled_q;

endmodule
